// File: rtl/wb_slave_pkg.sv
// Shared types and constants for the Wishbone register-memory slave.
// FSM state encoding, statistics counter width and a saturating increment helper.
package wb_slave_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  localparam int               COUNT_WIDTH = 16;
  localparam logic [15:0]      COUNT_MAX   = 16'hFFFF;

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
    return (v == COUNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/wb_slave_mem_if.sv
// Wishbone classic bus bundle between the test master and the register-memory slave.
// err_o rides along so the master sees the sticky range-error flag with the bus.
interface wb_slave_mem_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  cyc_i;
  logic                  stb_i;
  logic                  we_i;
  logic [ADDR_WIDTH-1:0] adr_i;
  logic [DATA_WIDTH-1:0] dat_i;
  logic [DATA_WIDTH-1:0] dat_o;
  logic                  ack_o;
  logic                  err_o;

  modport master (output cyc_i, stb_i, we_i, adr_i, dat_i,
                  input  dat_o, ack_o, err_o);
  modport slave  (input  cyc_i, stb_i, we_i, adr_i, dat_i,
                  output dat_o, ack_o, err_o);
endinterface

// File: rtl/wb_slave_ram.sv
// Word array for the slave: synchronous write, combinational read, cleared on reset.
module wb_slave_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 16,
  parameter int IDX_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [IDX_W-1:0]      idx,
  input  logic [DATA_WIDTH-1:0] wdat,
  output logic [DATA_WIDTH-1:0] rdat
);

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [MEM_DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[idx] = wdat;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdat = mem_q[idx];

endmodule

// File: rtl/wb_slave_mem.sv
// Wishbone classic slave: word-addressed memory with programmable wait states,
// range protection (acked, write dropped, read zero, sticky err) and saturating access counts.
module wb_slave_mem
  import wb_slave_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDRESS = '0,
  parameter int                    MEM_DEPTH    = 16,
  parameter int                    WAIT_STATES  = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  wb_slave_mem_if.slave          bus,
  output logic [COUNT_WIDTH-1:0] wr_count,
  output logic [COUNT_WIDTH-1:0] rd_count
);

  localparam int         IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t                  state_q, state_d;
  logic [3:0]              wait_q, wait_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
  logic [DATA_WIDTH-1:0]   wdat_q, wdat_d;
  logic [DATA_WIDTH-1:0]   rdat_q, rdat_d;
  logic                    ack_q, ack_d;
  logic                    err_q, err_d;
  logic [COUNT_WIDTH-1:0]  wr_cnt_q, wr_cnt_d;
  logic [COUNT_WIDTH-1:0]  rd_cnt_q, rd_cnt_d;

  logic [ADDR_WIDTH-1:0]   offset;
  logic                    in_range;
  logic [IDX_W-1:0]        idx;
  logic                    ram_we;
  logic [DATA_WIDTH-1:0]   ram_rdat;

  // Subtraction wraps, so addresses below the base land far out of range.
  assign offset   = adr_q - BASE_ADDRESS;
  assign in_range = (offset < ADDR_WIDTH'(MEM_DEPTH));
  assign idx      = offset[IDX_W-1:0];
  assign ram_we   = (state_q == S_ACK) && we_q && in_range;

  wb_slave_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH),
    .IDX_W      (IDX_W)
  ) u_ram (
    .clk  (clk),
    .rst  (rst),
    .we   (ram_we),
    .idx  (idx),
    .wdat (wdat_q),
    .rdat (ram_rdat)
  );

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    we_d     = we_q;
    adr_d    = adr_q;
    wdat_d   = wdat_q;
    rdat_d   = rdat_q;
    ack_d    = 1'b0;
    err_d    = err_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    case (state_q)
      S_IDLE: begin
        // The cycle where ack is high is the mandatory idle gap before a new request.
        if (bus.cyc_i && bus.stb_i && !ack_q) begin
          we_d   = bus.we_i;
          adr_d  = bus.adr_i;
          wdat_d = bus.dat_i;
          if (WAIT_STATES == 0) begin
            state_d = S_ACK;
          end else begin
            wait_d  = WAIT_LOAD;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!bus.cyc_i)          state_d = S_IDLE;
        else if (wait_q == 4'd0) state_d = S_ACK;
        else                     wait_d  = wait_q - 4'd1;
      end
      S_ACK: begin
        ack_d   = 1'b1;
        state_d = S_IDLE;
        if (!in_range) err_d = 1'b1;
        if (we_q) begin
          wr_cnt_d = sat_inc(wr_cnt_q);
        end else begin
          rdat_d   = in_range ? ram_rdat : '0;
          rd_cnt_d = sat_inc(rd_cnt_q);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      wait_q   <= '0;
      we_q     <= 1'b0;
      adr_q    <= '0;
      wdat_q   <= '0;
      rdat_q   <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      we_q     <= we_d;
      adr_q    <= adr_d;
      wdat_q   <= wdat_d;
      rdat_q   <= rdat_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  assign bus.dat_o = rdat_q;
  assign bus.ack_o = ack_q;
  assign bus.err_o = err_q;
  assign wr_count  = wr_cnt_q;
  assign rd_count  = rd_cnt_q;

endmodule

// File: tb/tb_wb_slave_mem.sv
// Bench for wb_slave_mem: three instances (0/3/5 wait states, one with a 0x100 base)
// driven by directed and random transfers, checked against an array-based memory model.
module tb_wb_slave_mem;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        we  = 1'b0;
  logic [31:0] adr = '0;
  logic [31:0] dat = '0;
  int          sel = 0;

  always #5 clk = ~clk;

  wb_slave_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus0 ();
  wb_slave_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus1 ();
  wb_slave_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus2 ();

  assign bus0.cyc_i = cyc && (sel == 0);
  assign bus1.cyc_i = cyc && (sel == 1);
  assign bus2.cyc_i = cyc && (sel == 2);
  assign bus0.stb_i = stb && (sel == 0);
  assign bus1.stb_i = stb && (sel == 1);
  assign bus2.stb_i = stb && (sel == 2);
  assign bus0.we_i = we;   assign bus1.we_i = we;   assign bus2.we_i = we;
  assign bus0.adr_i = adr; assign bus1.adr_i = adr; assign bus2.adr_i = adr;
  assign bus0.dat_i = dat; assign bus1.dat_i = dat; assign bus2.dat_i = dat;

  logic [15:0] wrc0, wrc1, wrc2, rdc0, rdc1, rdc2;

  wb_slave_mem #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .BASE_ADDRESS(32'h0),
                 .MEM_DEPTH(16), .WAIT_STATES(0))
    u_dut0 (.clk(clk), .rst(rst), .bus(bus0), .wr_count(wrc0), .rd_count(rdc0));
  wb_slave_mem #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .BASE_ADDRESS(32'h100),
                 .MEM_DEPTH(16), .WAIT_STATES(3))
    u_dut1 (.clk(clk), .rst(rst), .bus(bus1), .wr_count(wrc1), .rd_count(rdc1));
  wb_slave_mem #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .BASE_ADDRESS(32'h0),
                 .MEM_DEPTH(16), .WAIT_STATES(5))
    u_dut2 (.clk(clk), .rst(rst), .bus(bus2), .wr_count(wrc2), .rd_count(rdc2));

  logic        ack_m, err_m;
  logic [31:0] dat_m;
  logic [15:0] wrc_m, rdc_m;

  always_comb begin
    case (sel)
      0:       begin ack_m = bus0.ack_o; err_m = bus0.err_o; dat_m = bus0.dat_o; wrc_m = wrc0; rdc_m = rdc0; end
      1:       begin ack_m = bus1.ack_o; err_m = bus1.err_o; dat_m = bus1.dat_o; wrc_m = wrc1; rdc_m = rdc1; end
      default: begin ack_m = bus2.ack_o; err_m = bus2.err_o; dat_m = bus2.dat_o; wrc_m = wrc2; rdc_m = rdc2; end
    endcase
  end

  // Reference model: per-instance memory image, last read value, sticky error, counts.
  int          ws_tab   [3] = '{0, 3, 5};
  logic [31:0] base_tab [3] = '{32'h0, 32'h100, 32'h0};
  logic [31:0] mdl_mem  [3][16];
  logic [31:0] mdl_dat  [3];
  bit          mdl_err  [3];
  int          mdl_wr   [3];
  int          mdl_rd   [3];

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 16; i++) mdl_mem[k][i] = '0;
      mdl_dat[k] = '0;
      mdl_err[k] = 1'b0;
      mdl_wr[k]  = 0;
      mdl_rd[k]  = 0;
    end
  endtask

  task automatic xfer(input int k, input bit w, input logic [31:0] a, input logic [31:0] d);
    int          n;
    bit          seen;
    logic [31:0] off;
    sel = k; we = w; adr = a; dat = d; cyc = 1'b1; stb = 1'b1;
    n = 0; seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #1;
      n++;
      seen = ack_m;
    end
    cyc = 1'b0; stb = 1'b0;
    check("ack_seen", seen, 1);
    check("ack_latency", n - 1, ws_tab[k] + 1);
    off = a - base_tab[k];
    if (off >= 32'd16) mdl_err[k] = 1'b1;
    if (w) begin
      if (off < 32'd16) mdl_mem[k][off[3:0]] = d;
      if (mdl_wr[k] < 65535) mdl_wr[k]++;
    end else begin
      mdl_dat[k] = (off < 32'd16) ? mdl_mem[k][off[3:0]] : 32'h0;
      if (mdl_rd[k] < 65535) mdl_rd[k]++;
    end
    check("dat_o", dat_m, mdl_dat[k]);
    check("err_o", err_m, mdl_err[k]);
    check("wr_count", wrc_m, mdl_wr[k]);
    check("rd_count", rdc_m, mdl_rd[k]);
    @(posedge clk); #1;
    check("ack_one_cycle", ack_m, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          w;
    int          k, r;
    logic [31:0] a;
    bit          any_ack;

    model_reset();
    #2;
    for (int i = 0; i < 3; i++) begin
      sel = i; #1;
      check("rst_ack", ack_m, 0);
      check("rst_dat", dat_m, 0);
      check("rst_err", err_m, 0);
      check("rst_wr", wrc_m, 0);
      check("rst_rd", rdc_m, 0);
    end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;

    // Full sweep on a fresh instance: write all 16 words, read them back.
    for (int i = 0; i < 16; i++) xfer(0, 1'b1, i, i * 32'h11111111);
    for (int i = 0; i < 16; i++) xfer(0, 1'b0, i, 32'h0);
    check("sweep_wr", wrc_m, 16);
    check("sweep_rd", rdc_m, 16);
    check("sweep_err", err_m, 0);

    // Zero wait states: write-then-read of the same word returns the new data.
    xfer(0, 1'b1, 32'd1, 32'h11111111);
    xfer(0, 1'b0, 32'd1, 32'h0);
    check("wr_rd_same", dat_m, 32'h11111111);

    // Three wait states plus out-of-range handling around base 0x100.
    xfer(1, 1'b1, 32'h105, 32'hA5A5_0105);
    xfer(1, 1'b1, 32'h0FF, 32'hDEAD_00FF);
    xfer(1, 1'b1, 32'h110, 32'hDEAD_0110);
    check("oor_err", err_m, 1);
    xfer(1, 1'b0, 32'h110, 32'h0);
    check("oor_rd_zero", dat_m, 0);
    xfer(1, 1'b0, 32'h10F, 32'h0);
    xfer(1, 1'b0, 32'h100, 32'h0);
    xfer(1, 1'b0, 32'h105, 32'h0);

    // Random mix across all instances, including just-past-the-end and below-base.
    for (int t = 0; t < 60; t++) begin
      k = $urandom_range(0, 2);
      w = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 19);
      a = (r == 19) ? base_tab[k] - 32'd1 : base_tab[k] + r;
      xfer(k, w, a, $urandom);
    end

    // Abort during wait states: no ack, no write, counts untouched.
    xfer(2, 1'b1, 32'd7, 32'h0BAD_F00D);
    sel = 2; we = 1'b1; adr = 32'd7; dat = 32'h1234_5678; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    any_ack = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (ack_m) any_ack = 1'b1;
    end
    check("abort_no_ack", any_ack, 0);
    check("abort_wr", wrc_m, mdl_wr[2]);
    check("abort_rd", rdc_m, mdl_rd[2]);
    xfer(2, 1'b0, 32'd7, 32'h0);
    check("abort_word", dat_m, 32'h0BAD_F00D);

    // Reset while a transfer sits in wait states.
    xfer(2, 1'b1, 32'd3, 32'hCAFE_F00D);
    sel = 2; we = 1'b1; adr = 32'd3; dat = 32'h5555_AAAA; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    cyc = 1'b0; stb = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      sel = i; #1;
      check("midrst_ack", ack_m, 0);
      check("midrst_dat", dat_m, 0);
      check("midrst_err", err_m, 0);
      check("midrst_wr", wrc_m, 0);
      check("midrst_rd", rdc_m, 0);
    end
    model_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    xfer(2, 1'b0, 32'd3, 32'h0);
    check("midrst_word", dat_m, 0);
    xfer(0, 1'b0, 32'd1, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
